// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback-queue entry layout.
//   WB_DEPTH / WB_AW / WB_DW : default queue depth, register address width, data width
//   wb_entry_t               : one queue slot (valid, destination register, result data)
package cpu_pkg;

  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned WB_AW    = 5;
  localparam int unsigned WB_DW    = 32;

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Pending-write lookup for one register read port of the writeback queue.
// Ports:
//   valid_i    : per-slot occupied flags
//   addr_i     : per-slot destination register
//   r_addr_i   : register being read; address 0 never reports pending
//   pend_o     : some occupied slot targets r_addr_i (combinational)
// Optional (WB_FORWARD_EN):
//   data_i     : per-slot result data
//   head_i     : slot index of the oldest entry, used to order matches by age
//   fwd_data_o : data of the youngest matching slot, 0 when nothing pending
module wbq_match
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned AW    = WB_AW
`ifdef WB_FORWARD_EN
  ,
  parameter int unsigned DW    = WB_DW
`endif
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [AW-1:0]            addr_i [DEPTH],
`ifdef WB_FORWARD_EN
  input  logic [DW-1:0]            data_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head_i,
`endif
  input  logic [AW-1:0]            r_addr_i,
  output logic                     pend_o
`ifdef WB_FORWARD_EN
  ,
  output logic [DW-1:0]            fwd_data_o
`endif
);

  logic [DEPTH-1:0] hit;

  // Per-slot address compare against the read port.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit[i] = valid_i[i] && (addr_i[i] == r_addr_i);
    end
  end

  assign pend_o = (r_addr_i != '0) && (|hit);

`ifdef WB_FORWARD_EN
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk slots oldest to youngest from head; the last hit seen is the youngest.
  always_comb begin
    fwd_data_o = '0;
    idx        = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (pend_o && hit[idx]) begin
        fwd_data_o = data_i[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers (register, result) pairs and drains them in order
// into the register file whenever its write port is free.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   In_Valid/In_Ready     : producer handshake; In_Addr/In_Data are the offered result
//   Drain_En              : register-file write port is free this cycle
//   Write_Reg/W_Addr/W_Data : write strobe and head entry (0 when empty)
//   R_Addr_A/B, Pend_A/B  : read-port hazard lookup
//   Count                 : occupied entries
// Optional macro WB_FORWARD_EN adds Fwd_Data_A/B (youngest matching data).
module writeback_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  input  logic [AW-1:0]          In_Addr,
  input  logic [DW-1:0]          In_Data,
  input  logic                   Drain_En,
  output logic                   Write_Reg,
  output logic [AW-1:0]          W_Addr,
  output logic [DW-1:0]          W_Data,
  input  logic [AW-1:0]          R_Addr_A,
  input  logic [AW-1:0]          R_Addr_B,
  output logic                   Pend_A,
  output logic                   Pend_B,
  output logic [$clog2(DEPTH):0] Count
`ifdef WB_FORWARD_EN
  ,
  output logic [DW-1:0]          Fwd_Data_A,
  output logic [DW-1:0]          Fwd_Data_B
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];

  logic push_en;
  logic pop_en;
  logic not_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake and drain decisions come only from registered occupancy.
  assign not_empty = (count_q != '0);
  assign In_Ready  = (count_q < CNT_W'(DEPTH));
  // Register 0 is hardwired: the handshake completes but nothing is stored.
  assign push_en   = In_Valid && In_Ready && (In_Addr != '0);
  assign pop_en    = not_empty && Drain_En;

  assign Write_Reg = pop_en;
  assign W_Addr    = not_empty ? addr_q[head_q] : '0;
  assign W_Data    = not_empty ? data_q[head_q] : '0;
  assign Count     = count_q;

  // Next-state: pop frees the head slot, push fills the tail slot.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (pop_en) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    if (push_en) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = In_Addr;
      data_d[tail_q]  = In_Data;
      tail_d          = ptr_inc(tail_q);
    end
    count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
  end

  // State registers; reset wins over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // One lookup per read port; the head slot stays pending while it drains.
  wbq_match #(
    .DEPTH(DEPTH),
    .AW   (AW)
`ifdef WB_FORWARD_EN
    ,
    .DW   (DW)
`endif
  ) u_match_a (
    .valid_i   (valid_q),
    .addr_i    (addr_q),
`ifdef WB_FORWARD_EN
    .data_i    (data_q),
    .head_i    (head_q),
    .fwd_data_o(Fwd_Data_A),
`endif
    .r_addr_i  (R_Addr_A),
    .pend_o    (Pend_A)
  );

  wbq_match #(
    .DEPTH(DEPTH),
    .AW   (AW)
`ifdef WB_FORWARD_EN
    ,
    .DW   (DW)
`endif
  ) u_match_b (
    .valid_i   (valid_q),
    .addr_i    (addr_q),
`ifdef WB_FORWARD_EN
    .data_i    (data_q),
    .head_i    (head_q),
    .fwd_data_o(Fwd_Data_B),
`endif
    .r_addr_i  (R_Addr_B),
    .pend_o    (Pend_B)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus random
// traffic against a queue-based reference model; drained writes are checked
// by a scoreboard monitor.
module tb_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   In_Valid;
  logic                   In_Ready;
  logic [AW-1:0]          In_Addr;
  logic [DW-1:0]          In_Data;
  logic                   Drain_En;
  logic                   Write_Reg;
  logic [AW-1:0]          W_Addr;
  logic [DW-1:0]          W_Data;
  logic [AW-1:0]          R_Addr_A;
  logic [AW-1:0]          R_Addr_B;
  logic                   Pend_A;
  logic                   Pend_B;
  logic [$clog2(DEPTH):0] Count;
`ifdef WB_FORWARD_EN
  logic [DW-1:0]          Fwd_Data_A;
  logic [DW-1:0]          Fwd_Data_B;
`endif

  writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Addr   (In_Addr),
    .In_Data   (In_Data),
    .Drain_En  (Drain_En),
    .Write_Reg (Write_Reg),
    .W_Addr    (W_Addr),
    .W_Data    (W_Data),
    .R_Addr_A  (R_Addr_A),
    .R_Addr_B  (R_Addr_B),
    .Pend_A    (Pend_A),
    .Pend_B    (Pend_B),
`ifdef WB_FORWARD_EN
    .Fwd_Data_A(Fwd_Data_A),
    .Fwd_Data_B(Fwd_Data_B),
`endif
    .Count     (Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t model_q[$];   // reference queue contents
  ent_t exp_wr_q[$];  // expected register-file writes, in order

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_pend(input logic [AW-1:0] ra);
    if (ra == '0) return 1'b0;
    foreach (model_q[i]) if (model_q[i].addr == ra) return 1'b1;
    return 1'b0;
  endfunction

`ifdef WB_FORWARD_EN
  function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] ra);
    logic [DW-1:0] r;
    r = '0;
    if (ra == '0) return r;
    foreach (model_q[i]) if (model_q[i].addr == ra) r = model_q[i].data;
    return r;
  endfunction
`endif

  // One clock: drive at negedge, check combinational outputs, update model at posedge.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic dr, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic r);
    logic acc;
    ent_t e;
    @(negedge clk);
    In_Valid = v; In_Addr = a; In_Data = d; Drain_En = dr;
    R_Addr_A = ra; R_Addr_B = rb; rst = r;
    #1;
    chk("in_ready",  DW'(In_Ready),  DW'(model_q.size() < DEPTH));
    chk("count",     DW'(Count),     DW'(model_q.size()));
    chk("write_reg", DW'(Write_Reg), DW'(model_q.size() > 0 && dr));
    chk("w_addr",    DW'(W_Addr),    model_q.size() > 0 ? DW'(model_q[0].addr) : '0);
    chk("w_data",    W_Data,         model_q.size() > 0 ? model_q[0].data : '0);
    chk("pend_a",    DW'(Pend_A),    DW'(exp_pend(ra)));
    chk("pend_b",    DW'(Pend_B),    DW'(exp_pend(rb)));
`ifdef WB_FORWARD_EN
    chk("fwd_a",     Fwd_Data_A,     exp_fwd(ra));
    chk("fwd_b",     Fwd_Data_B,     exp_fwd(rb));
`endif
    @(posedge clk);
    if (r) begin
      model_q.delete();
      exp_wr_q.delete();
    end else begin
      acc = v && (model_q.size() < DEPTH);
      if (dr && model_q.size() > 0) void'(model_q.pop_front());
      if (acc && a != '0) begin
        e.addr = a; e.data = d;
        model_q.push_back(e);
        exp_wr_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic dr);
    step(1'b0, '0, '0, dr, '0, '0, 1'b0);
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #3;
      if (Write_Reg === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: actual W_Addr=%0h W_Data=%0h required no write at %0t",
                   W_Addr, W_Data, $time);
        end else begin
          e = exp_wr_q.pop_front();
          chk("sb_addr", DW'(W_Addr), DW'(e.addr));
          chk("sb_data", W_Data, e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; In_Valid = 1'b0; In_Addr = '0; In_Data = '0; Drain_En = 1'b0;
    R_Addr_A = '0; R_Addr_B = '0;
    repeat (2) @(posedge clk);
    model_q.delete();
    exp_wr_q.delete();

    // Reset state
    idle(1'b1);

    // Empty path: one-cycle push-to-write latency
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, '0, '0, 1'b0);
    #1;
    chk("empty_wreg", DW'(Write_Reg), DW'(1));
    chk("empty_addr", DW'(W_Addr), DW'(5));
    chk("empty_data", W_Data, 32'hDEADBEEF);
    idle(1'b1);
    #1;
    chk("empty_cnt0", DW'(Count), DW'(0));

    // Full path: fill, hold a fifth offer, then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), DW'(32'hA0 + i), 1'b0, '0, '0, 1'b0);
    #1;
    chk("full_cnt", DW'(Count), DW'(4));
    chk("full_rdy", DW'(In_Ready), DW'(0));
    step(1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 1'b0);
    step(1'b1, 5'd9, 32'h99, 1'b1, '0, '0, 1'b0);
    step(1'b1, 5'd9, 32'h99, 1'b1, '0, '0, 1'b0);
    repeat (6) idle(1'b1);

    // Pending / forwarding: two writes to r3, youngest wins
    step(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, 1'b0);
    step(1'b1, 5'd3, 32'h22, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 5'd3, 5'd0, 1'b0);
    #1;
    chk("pend_a_r3", DW'(Pend_A), DW'(1));
    chk("pend_b_r0", DW'(Pend_B), DW'(0));
`ifdef WB_FORWARD_EN
    chk("fwd_a_r3", Fwd_Data_A, 32'h22);
`endif
    repeat (3) idle(1'b1);

    // Address 0: handshake completes, nothing queued or written
    step(1'b1, 5'd0, 32'h55, 1'b1, '0, '0, 1'b0);
    #1;
    chk("a0_cnt", DW'(Count), DW'(0));
    idle(1'b1);

    // Reset mid-operation discards queued entries
    for (int i = 0; i < 3; i++) step(1'b1, AW'(7 + i), DW'(32'h700 + i), 1'b0, '0, '0, 1'b0);
    step(1'b1, 5'd12, 32'h1, 1'b1, 5'd7, 5'd8, 1'b1);
    #1;
    chk("rst_cnt",  DW'(Count), DW'(0));
    chk("rst_wreg", DW'(Write_Reg), DW'(0));
    chk("rst_pend", DW'(Pend_A), DW'(0));
    chk("rst_rdy",  DW'(In_Ready), DW'(1));
    idle(1'b1);

    // Wrap-around: steady push+pop at Count=2
    step(1'b1, 5'd20, 32'hB00, 1'b0, '0, '0, 1'b0);
    step(1'b1, 5'd21, 32'hB01, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, AW'(22 + i), DW'(32'hB02 + i), 1'b1, AW'(22 + i), 5'd21, 1'b0);
    #1;
    chk("wrap_cnt", DW'(Count), DW'(2));
    repeat (3) idle(1'b1);

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), 1'($urandom_range(0, 63) == 0));
    end

    repeat (DEPTH + 2) idle(1'b1);
    @(negedge clk);
    #4;
    chk("sb_empty", DW'(exp_wr_q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter DW, default 32, register data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-006 SHALL have port In_Valid  input  1  producer offers a result.
REQ-007 SHALL have port In_Ready  output  1  queue can accept this cycle.
REQ-008 SHALL have port In_Addr  input  AW  destination register of offered result.
REQ-009 SHALL have port In_Data  input  DW  offered result value.
REQ-010 SHALL have port Drain_En  input  1  register-file write port free this cycle.
REQ-011 SHALL have port Write_Reg  output  1  write strobe to register stack.
REQ-012 SHALL have ports W_Addr (output, AW) and W_Data (output, DW), carrying the head entry's address and data.
REQ-013 SHALL have ports R_Addr_A and R_Addr_B  input  AW  read addresses to check for pending writes.
REQ-014 SHALL have ports Pend_A and Pend_B  output  1  high when the matching read address has a queued write.
REQ-015 SHALL have port Count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 SHALL implement a circular FIFO with head and tail pointers that wrap from DEPTH-1 to 0.
REQ-017 SHALL drive In_Ready = (Count < DEPTH), derived only from registered state; there is no same-cycle pop-to-push bypass.
REQ-018 SHALL accept when In_Valid && In_Ready; address 0 accepted but not enqueued (handshake completes, Count unchanged).
REQ-019 SHALL drive Write_Reg = (Count != 0) && Drain_En, combinationally, with W_Addr/W_Data = head entry; pop occurs on that edge.
REQ-020 SHALL give push-to-Write_Reg latency of exactly 1 cycle when empty and Drain_En high.
REQ-021 SHALL, on simultaneous push and pop, leave Count unchanged and advance both pointers.
REQ-022 SHALL hold W_Addr/W_Data at 0 when Count == 0.
REQ-023 SHALL assert Pend_x when any occupied entry has address == R_Addr_x and R_Addr_x != 0, combinationally.
REQ-024 SHALL treat the head entry being popped in the current cycle as still pending in that cycle.
REQ-025 SHALL never reorder entries; writes to the same address drain in acceptance order.

Reset
REQ-026 SHALL on rst clear Count, head, tail and all entry valid state; In_Ready=1, Write_Reg=0, Pend_A=Pend_B=0 in the following cycle.
REQ-027 SHALL discard queued entries on rst mid-operation; rst has priority over push and pop in the same cycle.
REQ-028 SHALL reset entry storage to zero so that no X appears on any output.

Configuration
REQ-029 SHALL, with WB_FORWARD_EN defined, add outputs Fwd_Data_A and Fwd_Data_B (DW), giving the data of the youngest occupied entry matching R_Addr_x, or 0 when Pend_x is low.
REQ-030 SHALL, without WB_FORWARD_EN, omit Fwd_Data_A/B entirely; consumers stall on Pend_x.

Structure
REQ-031 SHALL place default AW/DW/DEPTH constants and the entry struct (valid, addr, data) in shared package cpu_pkg.
REQ-032 SHALL implement address matching and youngest-match selection in one sub-module, wbq_match, instantiated once per read port.

Verification
REQ-033 SHALL check the empty path: push (5, 0xDEADBEEF) with Drain_En=1 -> next cycle Write_Reg=1, W_Addr=5, W_Data=0xDEADBEEF; then Count=0.
REQ-034 SHALL check the full path: Drain_En=0, push 4 entries -> Count=4, In_Ready=0; fifth offer held; Drain_En=1 -> entries drain in order, one per cycle.
REQ-035 SHALL check pending/forwarding: queue (3,0x11) then (3,0x22), R_Addr_A=3 -> Pend_A=1, Fwd_Data_A=0x22 (with WB_FORWARD_EN); R_Addr_B=0 -> Pend_B=0.
REQ-036 SHALL check address 0: push (0, 0x55) -> In_Ready handshake completes, Count stays 0, no Write_Reg.
REQ-037 SHALL check reset: 3 entries queued, rst for 1 cycle -> Count=0, Write_Reg=0, Pend_A=0, In_Ready=1 the next cycle.
REQ-038 SHALL check wrap-around: 10 alternating push/pop cycles at Count=2 -> pointers wrap, data order preserved, Count stays 2.
